// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and FSM state type.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/serial_adder_fulladder.sv
// 1-bit full-adder cell: s = a ^ b ^ c0, c1 = carry out.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c0,
  output logic s,
  output logic c1
);

  assign s  = a ^ b ^ c0;
  assign c1 = (a & b) | (c0 & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder evaluation per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic             r_c_reg;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_c1;
  logic [WIDTH-1:0] w_next_sr;

  fulladder u_fa (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .c0 (r_c_reg),
    .s  (w_s),
    .c1 (w_c1)
  );

  // New sum bit enters at the MSB; the concatenate-and-shift form also covers WIDTH=1.
  assign w_next_sr = WIDTH'({w_s, r_r_sr} >> 1);

  // NOTE: every register here, including the datapath shift registers, uses non-blocking
  // assignment and is cleared by the async reset so a mid-run reset leaves no stale state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_r_sr  <= '0;
      r_c_reg <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a_sr  <= a_in;
            r_b_sr  <= b_in;
            r_c_reg <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_r_sr  <= w_next_sr;
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_c_reg <= w_c1;
          if (r_cnt == LAST_CNT) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= w_next_sr;
            cout    <= w_c1;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB is still in r_c_reg on the final cell evaluation.
            ovf     <= r_c_reg ^ w_c1;
`endif
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances, directed vectors.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic [0:0] a1, b1, sum1;
  logic       cin1, busy1, done1, cout1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a_in  (a8),
    .b_in  (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a_in  (a1),
    .b_in  (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Start one 8-bit add; lat = number of negedges after the start edge until done is seen.
  task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hEE; b8 = 8'hEE; cin8 = 1'b1;
    lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_add1(input logic a, input logic b, input logic c, output int lat);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t       vecs[7];
  logic [7:0] ops_a[3];
  logic [7:0] ops_b[3];
  logic [7:0] exp_s[3];
  logic       exp_c[3];
  int         lat;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};

    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #3;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum",  32'(sum8),  32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single adds
    for (int i = 0; i < 7; i++) begin
      do_add8(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("vec%0d_lat", i),  32'(lat),   32'd9);
      check($sformatf("vec%0d_sum", i),  32'(sum8),  32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(cout8), 32'(vecs[i].cout));
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), 32'(done8), 32'd0);
      check($sformatf("vec%0d_hold", i),  32'(sum8),  32'(vecs[i].sum));
    end

    // Back-to-back: start held through DONE, toggled during RUN
    ops_a[0] = 8'h01; ops_b[0] = 8'h02; exp_s[0] = 8'h03; exp_c[0] = 1'b0;
    ops_a[1] = 8'h40; ops_b[1] = 8'h40; exp_s[1] = 8'h80; exp_c[1] = 1'b0;
    ops_a[2] = 8'hF0; ops_b[2] = 8'h20; exp_s[2] = 8'h10; exp_c[2] = 1'b1;
    begin
      int k = 0;
      int t = 0;
      int last = 0;
      @(negedge clk);
      a8 = ops_a[0]; b8 = ops_b[0]; cin8 = 1'b0; start8 = 1'b1;
      while (k < 3 && t < 60) begin
        @(negedge clk);
        t++;
        if (done8) begin
          check($sformatf("b2b%0d_gap", k),  32'(t - last), 32'd9);
          check($sformatf("b2b%0d_sum", k),  32'(sum8),     32'(exp_s[k]));
          check($sformatf("b2b%0d_cout", k), 32'(cout8),    32'(exp_c[k]));
          last = t;
          k++;
          if (k < 3) begin
            a8 = ops_a[k]; b8 = ops_b[k]; cin8 = 1'b0; start8 = 1'b1;
          end else begin
            start8 = 1'b0;
          end
        end else begin
          a8 = 8'hEE; b8 = 8'h11; cin8 = 1'b1; start8 = ~start8;
        end
      end
      check("b2b_count", 32'(k), 32'd3);
      @(negedge clk);
      check("b2b_idle_busy", 32'(busy8), 32'd0);
      check("b2b_idle_done", 32'(done8), 32'd0);
      check("b2b_idle_sum",  32'(sum8),  32'h10);
    end

    // Reset in RUN cycle 4 of 0x12+0x34
    begin
      logic saw_done = 1'b0;
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", 32'(busy8), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy8), 32'd0);
      check("abort_done", 32'(done8), 32'd0);
      check("abort_sum",  32'(sum8),  32'd0);
      check("abort_cout", 32'(cout8), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (done8 || busy8) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      do_add8(8'h12, 8'h34, 1'b0, lat);
      check("fresh_lat", 32'(lat),   32'd9);
      check("fresh_sum", 32'(sum8),  32'h46);
      check("fresh_cout", 32'(cout8), 32'd0);
    end

    // WIDTH=1: full-adder truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] tot;
      v   = 3'(i);
      tot = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      do_add1(v[2], v[1], v[0], lat);
      check($sformatf("w1_%0d_lat", i),  32'(lat),   32'd2);
      check($sformatf("w1_%0d_sum", i),  32'(sum1),  32'(tot[0]));
      check($sformatf("w1_%0d_cout", i), 32'(cout1), 32'(tot[1]));
    end

`ifdef SERIAL_ADDER_OVF_EN
    do_add8(8'h7F, 8'h01, 1'b0, lat);
    check("ovf1_sum", 32'(sum8), 32'h80);
    check("ovf1_ovf", 32'(ovf8), 32'd1);
    do_add8(8'h80, 8'h80, 1'b0, lat);
    check("ovf2_sum",  32'(sum8),  32'h00);
    check("ovf2_cout", 32'(cout8), 32'd1);
    check("ovf2_ovf",  32'(ovf8),  32'd1);
    do_add8(8'h10, 8'h20, 1'b0, lat);
    check("ovf3_sum", 32'(sum8), 32'h30);
    check("ovf3_ovf", 32'(ovf8), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
